// File: rtl/seat_display_ctrl.sv
// seat_display_ctrl: converts seat/money counts to BCD and scans them onto a 4-digit active-low 7-seg display.
module seat_display_ctrl #(
  parameter int SCAN_DIV = 17,
  parameter int BLINK_FRAMES = 32,
  parameter int LZ_BLANK = 0
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic [5:0] seat_left,
  input  logic [5:0] money_left,
  input  logic       alert,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state;
  logic [SCAN_DIV-1:0] pre;
  logic [1:0] digit;
  logic [7:0] fcnt;
  logic blink_ph, valid;
  logic [5:0] seat_bin, money_bin;
  logic [7:0] seat_bcd, money_bcd, seat_adj, money_adj;
  logic [2:0] iter;
  logic [3:0] seat_t, seat_o, money_t, money_o, cur;
  logic [6:0] glyph;
  logic tick, frame_tick, off;
  assign dp = 1'b1;
  always_comb begin
    tick = &pre;
    frame_tick = tick && digit == 2'd3;
    seat_adj = {seat_bcd[7:4] >= 4'd5 ? seat_bcd[7:4] + 4'd3 : seat_bcd[7:4],
                seat_bcd[3:0] >= 4'd5 ? seat_bcd[3:0] + 4'd3 : seat_bcd[3:0]};
    money_adj = {money_bcd[7:4] >= 4'd5 ? money_bcd[7:4] + 4'd3 : money_bcd[7:4],
                 money_bcd[3:0] >= 4'd5 ? money_bcd[3:0] + 4'd3 : money_bcd[3:0]};
    cur = digit == 2'd0 ? seat_o : digit == 2'd1 ? seat_t : digit == 2'd2 ? money_o : money_t;
    off = !valid || (alert && blink_ph) || (LZ_BLANK != 0 && digit[0] && cur == 4'd0);
    case (cur)
      4'd0: glyph = 7'b1000000;
      4'd1: glyph = 7'b1111001;
      4'd2: glyph = 7'b0100100;
      4'd3: glyph = 7'b0110000;
      4'd4: glyph = 7'b0011001;
      4'd5: glyph = 7'b0010010;
      4'd6: glyph = 7'b0000010;
      4'd7: glyph = 7'b1111000;
      4'd8: glyph = 7'b0000000;
      4'd9: glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  end
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state <= LOAD;
      pre <= '0;
      digit <= '0;
      fcnt <= '0;
      blink_ph <= 1'b0;
      valid <= 1'b0;
      seat_bin <= '0;
      money_bin <= '0;
      seat_bcd <= '0;
      money_bcd <= '0;
      iter <= '0;
      seat_t <= '0;
      seat_o <= '0;
      money_t <= '0;
      money_o <= '0;
      seg <= 7'b1111111;
      an <= 4'b1111;
    end else begin
      pre <= pre + 1'b1;
      if (tick) digit <= digit + 1'b1;
      if (frame_tick) begin
        fcnt <= fcnt == 8'(BLINK_FRAMES - 1) ? 8'd0 : fcnt + 1'b1;
        if (fcnt == 8'(BLINK_FRAMES - 1)) blink_ph <= ~blink_ph;
      end
      case (state)
        IDLE: if (frame_tick) state <= LOAD;
        LOAD: begin
          seat_bin <= seat_left;
          money_bin <= money_left;
          seat_bcd <= '0;
          money_bcd <= '0;
          iter <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          {seat_bcd, seat_bin} <= {seat_adj, seat_bin} << 1;
          {money_bcd, money_bin} <= {money_adj, money_bin} << 1;
          iter <= iter + 3'd1;
          if (iter == 3'd5) state <= DONE;
        end
        DONE: begin
          {seat_t, seat_o} <= seat_bcd;
          {money_t, money_o} <= money_bcd;
          valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      seg <= glyph;
      an <= off ? 4'b1111 : ~(4'b0001 << digit);
    end
  end
endmodule
